// File: rtl/timer_ctrl_16bit.sv
// ---------------------------------------------------------------------------
// timer_ctrl_16bit
// Prescaled 16-bit event timer with one-shot / periodic modes, pause/resume
// and sticky done / overrun flags.
//
// State table
//   state    | meaning
//   IDLE  00 | stopped, Q=0, waiting for Start
//   RUN   01 | prescaler running, Q advances on each prescaler tick
//   PAUSE 10 | Q and prescaler frozen; Start resumes, Stop aborts to IDLE
//   DONE  11 | one-shot reached terminal count, Q holds; Ack returns to IDLE
//
// Ports
//   Clk     rising-edge clock
//   Clr     synchronous active-high reset
//   Start   begin (from IDLE) or resume (from PAUSE)
//   Stop    pause (from RUN) or abort (from PAUSE); wins over Start
//   Mode    0 = one-shot, 1 = periodic (captured on start from IDLE)
//   Period  terminal count (captured on start from IDLE)
//   Presc   prescale divisor minus one (captured on start from IDLE)
//   Ack     clears Done and Ovf
//   Q       current count
//   En      one-cycle strobe following each prescaler tick
//   Busy    high in RUN or PAUSE
//   Done    sticky terminal-count flag
//   Ovf     sticky flag: terminal count reached while Done still set
//   State   encoded FSM state
// ---------------------------------------------------------------------------
module timer_ctrl_16bit (
   input  logic        Clk,
   input  logic        Clr,
   input  logic        Start,
   input  logic        Stop,
   input  logic        Mode,
   input  logic [15:0] Period,
   input  logic [7:0]  Presc,
   input  logic        Ack,
   output logic [15:0] Q,
   output logic        En,
   output logic        Busy,
   output logic        Done,
   output logic        Ovf,
   output logic [1:0]  State
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] q_q, q_d;
   logic [7:0]  p_q, p_d;
   logic        en_q, en_d;
   logic        done_q, done_d;
   logic        ovf_q, ovf_d;
   logic [15:0] period_s_q, period_s_d;
   logic [7:0]  presc_s_q, presc_s_d;
   logic        mode_s_q, mode_s_d;
   logic        done_set;
   logic        ovf_set;

   always_comb begin
      state_d    = state_q;
      q_d        = q_q;
      p_d        = p_q;
      en_d       = 1'b0;
      period_s_d = period_s_q;
      presc_s_d  = presc_s_q;
      mode_s_d   = mode_s_q;
      done_set   = 1'b0;
      ovf_set    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (Start && !Stop) begin
               period_s_d = Period;
               presc_s_d  = Presc;
               mode_s_d   = Mode;
               q_d        = 16'd0;
               p_d        = 8'd0;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (Stop) begin
               state_d = ST_PAUSE;
            end else if (p_q == presc_s_q) begin
               p_d  = 8'd0;
               en_d = 1'b1;
               if (q_q == period_s_q) begin
                  done_set = 1'b1;
                  if (mode_s_q) begin
                     q_d = 16'd0;
                     // An Ack arriving with the terminal tick consumes the old
                     // Done, so this tick is not an overrun.
                     ovf_set = done_q && !Ack;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  q_d = q_q + 16'd1;
               end
            end else begin
               p_d = p_q + 8'd1;
            end
         end
         ST_PAUSE: begin
            if (Stop) begin
               q_d     = 16'd0;
               p_d     = 8'd0;
               state_d = ST_IDLE;
            end else if (Start) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (Ack) begin
               q_d     = 16'd0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Set events win over a same-cycle Ack.
      done_d = done_set | (done_q & ~Ack);
      ovf_d  = ovf_set  | (ovf_q  & ~Ack);
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state_q    <= ST_IDLE;
         q_q        <= 16'd0;
         p_q        <= 8'd0;
         en_q       <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         period_s_q <= 16'd0;
         presc_s_q  <= 8'd0;
         mode_s_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         q_q        <= q_d;
         p_q        <= p_d;
         en_q       <= en_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         period_s_q <= period_s_d;
         presc_s_q  <= presc_s_d;
         mode_s_q   <= mode_s_d;
      end
   end

   assign Q     = q_q;
   assign En    = en_q;
   assign Busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign Done  = done_q;
   assign Ovf   = ovf_q;
   assign State = state_q;

endmodule

// File: tb/tb_timer_ctrl_16bit.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl_16bit
// Directed self-checking bench for timer_ctrl_16bit. Inputs change 1 ns after
// each rising edge; outputs are checked at the same point.
// ---------------------------------------------------------------------------
module tb_timer_ctrl_16bit;

   logic        Clk = 1'b0;
   logic        Clr, Start, Stop, Mode, Ack;
   logic [15:0] Period;
   logic [7:0]  Presc;
   logic [15:0] Q;
   logic        En, Busy, Done, Ovf;
   logic [1:0]  State;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;

   timer_ctrl_16bit dut (
      .Clk    (Clk),
      .Clr    (Clr),
      .Start  (Start),
      .Stop   (Stop),
      .Mode   (Mode),
      .Period (Period),
      .Presc  (Presc),
      .Ack    (Ack),
      .Q      (Q),
      .En     (En),
      .Busy   (Busy),
      .Done   (Done),
      .Ovf    (Ovf),
      .State  (State)
   );

   always #5 Clk = ~Clk;

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic [15:0] exp_q  [4] = '{16'd1, 16'd0, 16'd1, 16'd0};
      logic        exp_dn [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic        exp_ov [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

      Clr = 1'b1; Start = 1'b0; Stop = 1'b0; Mode = 1'b0; Ack = 1'b0;
      Period = 16'd0; Presc = 8'd0;
      step(2);
      chk("rst_state", State, S_IDLE);
      chk("rst_q", Q, 16'd0);
      chk("rst_en", En, 1'b0);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_done", Done, 1'b0);
      chk("rst_ovf", Ovf, 1'b0);

      // one-shot, Period=3, Presc=0
      Clr = 1'b0; Period = 16'd3; Presc = 8'd0; Mode = 1'b0; Start = 1'b1;
      step();
      Start = 1'b0;
      Period = 16'd7;   // must not affect the running timer
      chk("os_start_state", State, S_RUN);
      chk("os_start_q", Q, 16'd0);
      chk("os_start_en", En, 1'b0);
      chk("os_start_busy", Busy, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         step();
         chk("os_en", En, 1'b1);
         chk("os_q", Q, (i < 4) ? 16'(i) : 16'd3);
      end
      chk("os_done", Done, 1'b1);
      chk("os_state_done", State, S_DONE);
      Start = 1'b1;
      step();
      Start = 1'b0;
      chk("os_hold_en", En, 1'b0);
      chk("os_hold_q", Q, 16'd3);
      chk("os_start_ignored", State, S_DONE);
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      chk("os_ack_state", State, S_IDLE);
      chk("os_ack_q", Q, 16'd0);
      chk("os_ack_done", Done, 1'b0);

      // prescaled one-shot, Period=2, Presc=4: ticks every 5th cycle, done at 15
      Period = 16'd2; Presc = 8'd4; Mode = 1'b0; Start = 1'b1;
      step();
      Start = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         step();
         chk("ps_en", En, (i % 5 == 0) ? 16'd1 : 16'd0);
         if (i == 14) chk("ps_not_done", Done, 1'b0);
      end
      chk("ps_done", Done, 1'b1);
      chk("ps_state", State, S_DONE);
      chk("ps_q", Q, 16'd2);
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      chk("ps_ack_state", State, S_IDLE);

      // periodic overrun, Period=1, Presc=0
      Period = 16'd1; Presc = 8'd0; Mode = 1'b1; Start = 1'b1;
      step();
      Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("per_q", Q, exp_q[i]);
         chk("per_done", Done, exp_dn[i]);
         chk("per_ovf", Ovf, exp_ov[i]);
      end
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      chk("per_ack_done", Done, 1'b0);
      chk("per_ack_ovf", Ovf, 1'b0);
      chk("per_ack_state", State, S_RUN);
      chk("per_ack_q", Q, 16'd1);
      step();
      chk("per_redone", Done, 1'b1);
      chk("per_reovf", Ovf, 1'b0);
      step();
      chk("per_q1", Q, 16'd1);
      // Ack coincident with terminal tick: Done stays set, no overrun
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      chk("ack_tick_done", Done, 1'b1);
      chk("ack_tick_ovf", Ovf, 1'b0);
      chk("ack_tick_q", Q, 16'd0);
      Stop = 1'b1;
      step(2);
      Stop = 1'b0;
      chk("per_abort_state", State, S_IDLE);
      Ack = 1'b1;
      step();
      Ack = 1'b0;
      chk("per_clear_done", Done, 1'b0);

      // pause / resume, Period=10
      Period = 16'd10; Presc = 8'd0; Mode = 1'b0; Start = 1'b1;
      step();
      Start = 1'b0;
      step(4);
      chk("pr_q4", Q, 16'd4);
      Stop = 1'b1;
      step();
      Stop = 1'b0;
      chk("pr_pause_state", State, S_PAUSE);
      chk("pr_pause_en", En, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("pr_pause_q", Q, 16'd4);
         chk("pr_pause_busy", Busy, 1'b1);
      end
      chk("pr_still_paused", State, S_PAUSE);
      Start = 1'b1;
      step();
      Start = 1'b0;
      chk("pr_resume_state", State, S_RUN);
      chk("pr_resume_q", Q, 16'd4);
      step();
      chk("pr_q5", Q, 16'd5);
      step();
      chk("pr_q6", Q, 16'd6);
      Stop = 1'b1;
      step();
      chk("pr_stop1", State, S_PAUSE);
      step();
      Stop = 1'b0;
      chk("pr_stop2_state", State, S_IDLE);
      chk("pr_stop2_q", Q, 16'd0);
      chk("pr_stop2_busy", Busy, 1'b0);

      // Start and Stop together in IDLE
      Start = 1'b1; Stop = 1'b1;
      step();
      Start = 1'b0; Stop = 1'b0;
      chk("prio_idle", State, S_IDLE);

      // reset mid-run at Q=7
      Period = 16'd20; Presc = 8'd0; Mode = 1'b0; Start = 1'b1;
      step();
      Start = 1'b0;
      step(7);
      chk("clr_pre_q", Q, 16'd7);
      Clr = 1'b1; Start = 1'b1;
      step();
      Clr = 1'b0; Start = 1'b0;
      chk("clr_state", State, S_IDLE);
      chk("clr_q", Q, 16'd0);
      chk("clr_en", En, 1'b0);
      chk("clr_done", Done, 1'b0);
      chk("clr_ovf", Ovf, 1'b0);
      chk("clr_busy", Busy, 1'b0);

      // first cycle after reset starts normally with freshly latched Period
      Period = 16'd1; Start = 1'b1;
      step();
      Start = 1'b0;
      chk("post_clr_state", State, S_RUN);
      step(2);
      chk("post_clr_done", Done, 1'b1);
      chk("post_clr_q", Q, 16'd1);
      chk("post_clr_dstate", State, S_DONE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_ctrl_16bit.md
TIMER_CTRL_16BIT -- requirements
Module: timer_ctrl_16bit

Interface
REQ-001 SHALL have parameter none; all widths fixed (16-bit count, 8-bit prescale).
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Clr  input  1  synchronous active-high reset, sampled on Clk rising edge.
REQ-004 Start  input  1  level, sampled each cycle; begin or resume counting.
REQ-005 Stop  input  1  level, sampled each cycle; pause, or abort from pause.
REQ-006 Mode  input  1  0 = one-shot, 1 = periodic; latched at start from IDLE.
REQ-007 Period  input  16  terminal count value; latched at start from IDLE.
REQ-008 Presc  input  8  prescale divisor minus one; latched at start from IDLE.
REQ-009 Ack  input  1  clears Done and Ovf flags.
REQ-010 Q  output  16  current count value (registered).
REQ-011 En  output  1  one-cycle count-enable strobe (prescaler tick), registered.
REQ-012 Busy  output  1  high in RUN or PAUSE.
REQ-013 Done  output  1  sticky terminal-count flag.
REQ-014 Ovf  output  1  sticky flag: terminal count reached while Done already set.
REQ-015 State  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-016 FSM states SHALL be IDLE, RUN, PAUSE, DONE, all transitions on Clk rising edge.
REQ-017 Stop and Start asserted in the same cycle: Stop SHALL take priority.
REQ-018 IDLE + Start: latch Period/Presc/Mode to shadow regs, Q<=0, prescale count P<=0, go RUN next cycle.
REQ-019 RUN: P SHALL increment each cycle; when P==shadow Presc, P<=0 and a tick occurs.
REQ-020 En SHALL be 1 in the cycle after a tick, 0 otherwise; Presc=0 gives a tick every RUN cycle.
REQ-021 Tick with Q!=shadow Period: Q<=Q+1.
REQ-022 Tick with Q==shadow Period, one-shot: Q holds, Done<=1, go DONE.
REQ-023 Tick with Q==shadow Period, periodic: Q<=0, Done<=1, stay RUN; if Done already 1 (and not cleared this cycle), Ovf<=1.
REQ-024 Period=0: every tick SHALL be a terminal tick.
REQ-025 RUN + Stop: go PAUSE; Q and P hold; no tick, En=0.
REQ-026 PAUSE + Start (no Stop): return to RUN, resuming from held Q and P; shadow regs unchanged.
REQ-027 PAUSE + Stop: go IDLE, Q<=0, P<=0.
REQ-028 Start in RUN or DONE SHALL be ignored; Stop in IDLE or DONE SHALL be ignored.
REQ-029 DONE: Q holds terminal value; Ack SHALL move to IDLE with Q<=0.
REQ-030 Ack SHALL clear Done and Ovf in any state; a same-cycle set event SHALL win over Ack.
REQ-031 Period/Presc/Mode input changes outside an IDLE start SHALL have no effect.
REQ-032 Q arithmetic SHALL be 16-bit unsigned; Q SHALL never exceed shadow Period.

Reset
REQ-033 Clr=1 SHALL force State=IDLE, Q=0, P=0, En=0, Busy=0, Done=0, Ovf=0, shadow regs=0, overriding all other inputs including mid-RUN.
REQ-034 First cycle after Clr deasserts SHALL behave as IDLE with inputs sampled normally.

Verification
REQ-035 One-shot: Period=3, Presc=0, Start 1 cycle -> En high 4 consecutive cycles, Q 0,1,2,3, Done=1, State=DONE; Ack -> IDLE, Q=0, Done=0.
REQ-036 Prescale: Period=2, Presc=4, one-shot -> En every 5th cycle, Done after 15 RUN cycles.
REQ-037 Periodic overrun: Period=1, Presc=0, Mode=1, no Ack -> Q 0,1,0,1..., Done=1 after 2nd tick, Ovf=1 after 4th tick; Ack -> both 0, RUN continues.
REQ-038 Pause/resume: Period=10, Presc=0, Stop at Q=4 -> Q holds 4 in PAUSE for 5 cycles; Start -> Q continues 5,6...; Stop twice -> IDLE, Q=0.
REQ-039 Priority: Start+Stop together in IDLE -> stays IDLE; Ack same cycle as terminal tick -> Done=1.
REQ-040 Reset mid-operation: Clr during RUN at Q=7 -> next cycle State=IDLE, Q=0, En=0, flags 0.
